// File: rtl/ms_clk_rst_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
package ms_clk_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_RST     = 2'b00,
    CAUSE_EXT     = 2'b01,
    CAUSE_SW      = 2'b10,
    CAUSE_CLKFAIL = 2'b11
  } cause_e;

  // Priority among coincident triggers: external > clock failure > software.
  function automatic cause_e f_cause(input logic i_ext, input logic i_fail);
    if (i_ext)       return CAUSE_EXT;
    else if (i_fail) return CAUSE_CLKFAIL;
    else             return CAUSE_SW;
  endfunction

endpackage

// File: rtl/ms_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input, with selectable reset level.
module ms_sync
  import ms_clk_rst_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= {STAGES{RST_VAL}};
    else     r_sync <= STAGES'({r_sync, i_d});
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ms_rst_seq.sv
// Ordered multi-domain reset release with programmable per-domain delays,
// external-clock stall monitor with internal-oscillator fallback, and last-reset cause.
module ms_rst_seq
  import ms_clk_rst_pkg::*;
#(
  parameter int unsigned NUM_DOM     = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MIN_HOLD    = 16,
  parameter int unsigned MON_TIMEOUT = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       xrst_n,
  input  logic                       sw_rst_req,
  input  logic                       mon_en,
  input  logic                       mon_clk_in,
  input  logic                       fail_clr,
  input  logic [NUM_DOM*CNT_W-1:0]   dly,
  output logic [NUM_DOM-1:0]         dom_rst_n,
  output logic                       all_rdy,
  output logic                       clk_fail,
  output logic                       fallback_sel,
  output logic [1:0]                 rst_cause
);

  localparam int unsigned IDX_W  = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int unsigned MON_W  = $clog2(MON_TIMEOUT + 1);

  logic w_xrst_sync;
  logic w_mon_sync;

  ms_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_xrst (
    .clk (clk),
    .rst (rst),
    .i_d (xrst_n),
    .o_q (w_xrst_sync)
  );

  ms_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mon (
    .clk (clk),
    .rst (rst),
    .i_d (mon_clk_in),
    .o_q (w_mon_sync)
  );

  // External clock activity monitor
  logic             r_mon_prev;
  logic [MON_W-1:0] r_mon_cnt;
  logic             r_clk_fail;
  logic             w_mon_edge;
  logic             w_fail_set;
  logic             w_fail_rise;

  assign w_mon_edge  = w_mon_sync ^ r_mon_prev;
  assign w_fail_set  = mon_en && (r_mon_cnt == MON_W'(MON_TIMEOUT - 1));
  // Flag rises on the same edge the sequencer drops all domains.
  assign w_fail_rise = w_fail_set && !r_clk_fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mon_prev <= 1'b0;
      r_mon_cnt  <= '0;
      r_clk_fail <= 1'b0;
    end else begin
      r_mon_prev <= w_mon_sync;
      if (!mon_en || w_mon_edge)
        r_mon_cnt <= '0;
      else if (r_mon_cnt != MON_W'(MON_TIMEOUT))
        r_mon_cnt <= r_mon_cnt + MON_W'(1);
      if (w_fail_set)    r_clk_fail <= 1'b1;
      else if (fail_clr) r_clk_fail <= 1'b0;
    end
  end

  // Sequencer state
  state_e             r_state;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_dly_cnt;
  logic [NUM_DOM-1:0] r_dom_rst_n;
  logic               r_all_rdy;
  cause_e             r_cause;

  state_e             w_state_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   w_dly_cnt_nxt;
  logic [NUM_DOM-1:0] w_dom_nxt;
  logic               w_rdy_nxt;
  cause_e             w_cause_nxt;

  logic               w_trig;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [CNT_W-1:0]   w_dly_reload;

  assign w_trig    = !w_xrst_sync || sw_rst_req || w_fail_rise;
  assign w_idx_inc = r_idx + IDX_W'(1);

  // Delay for the next domain, sampled only at the moment of reload.
  always_comb begin
    w_dly_reload = '0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      if (IDX_W'(i) == w_idx_inc) w_dly_reload = dly[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HOLD;
      r_hold_cnt  <= '0;
      r_idx       <= '0;
      r_dly_cnt   <= '0;
      r_dom_rst_n <= '0;
      r_all_rdy   <= 1'b0;
      r_cause     <= CAUSE_RST;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_idx       <= w_idx_nxt;
      r_dly_cnt   <= w_dly_cnt_nxt;
      r_dom_rst_n <= w_dom_nxt;
      r_all_rdy   <= w_rdy_nxt;
      r_cause     <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_idx_nxt     = r_idx;
    w_dly_cnt_nxt = r_dly_cnt;
    w_dom_nxt     = r_dom_rst_n;
    w_rdy_nxt     = r_all_rdy;
    w_cause_nxt   = r_cause;

    if (w_trig) begin
      w_state_nxt = HOLD;
      w_hold_nxt  = '0;
      w_dom_nxt   = '0;
      w_rdy_nxt   = 1'b0;
      w_cause_nxt = f_cause(!w_xrst_sync, w_fail_rise);
    end else begin
      unique case (r_state)
        HOLD: begin
          if (r_hold_cnt == HOLD_W'(MIN_HOLD - 1)) begin
            w_state_nxt   = RELEASE;
            w_idx_nxt     = '0;
            w_dly_cnt_nxt = dly[CNT_W-1:0];
          end else begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
          end
        end
        RELEASE: begin
          if (r_dly_cnt == '0) begin
            for (int unsigned i = 0; i < NUM_DOM; i++) begin
              if (IDX_W'(i) == r_idx) w_dom_nxt[i] = 1'b1;
            end
            if (r_idx == IDX_W'(NUM_DOM - 1)) begin
              w_state_nxt = RUN;
              w_rdy_nxt   = 1'b1;
            end else begin
              w_idx_nxt     = w_idx_inc;
              w_dly_cnt_nxt = w_dly_reload;
            end
          end else begin
            w_dly_cnt_nxt = r_dly_cnt - CNT_W'(1);
          end
        end
        RUN: begin
          w_rdy_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = HOLD;
          w_hold_nxt  = '0;
          w_dom_nxt   = '0;
          w_rdy_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign dom_rst_n    = r_dom_rst_n;
  assign all_rdy      = r_all_rdy;
  assign clk_fail     = r_clk_fail;
  assign fallback_sel = r_clk_fail;
  assign rst_cause    = r_cause;

endmodule

// File: tb/tb_ms_rst_seq.sv
// Directed bench for ms_rst_seq: release spacing, triggers, cause priority and clock monitor.
module tb_ms_rst_seq;

  localparam int unsigned NUM_DOM  = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned MIN_HOLD = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     xrst_n;
  logic                     sw_rst_req;
  logic                     mon_en;
  logic                     mon_clk_in;
  logic                     fail_clr;
  logic [NUM_DOM*CNT_W-1:0] dly;
  logic [NUM_DOM-1:0]       dom_rst_n;
  logic                     all_rdy;
  logic                     clk_fail;
  logic                     fallback_sel;
  logic [1:0]               rst_cause;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ms_rst_seq #(
    .NUM_DOM(NUM_DOM), .CNT_W(CNT_W), .MIN_HOLD(MIN_HOLD),
    .MON_TIMEOUT(64), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .xrst_n(xrst_n), .sw_rst_req(sw_rst_req),
    .mon_en(mon_en), .mon_clk_in(mon_clk_in), .fail_clr(fail_clr), .dly(dly),
    .dom_rst_n(dom_rst_n), .all_rdy(all_rdy), .clk_fail(clk_fail),
    .fallback_sel(fallback_sel), .rst_cause(rst_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at the edge where the last trigger cleared the hold counter.
  // Domain i releases at t[i]: t0 = MIN_HOLD+d0+1, t[i] = t[i-1]+d[i]+1.
  // chg_dly is applied to the dly input just before edge chg_k (0 = never).
  task automatic check_seq(input string tag, input int d0, input int d1, input int d2,
                           input int d3, input int chg_k, input logic [31:0] chg_dly);
    int t[4];
    logic [3:0] e;
    t[0] = MIN_HOLD + d0 + 1;
    t[1] = t[0] + d1 + 1;
    t[2] = t[1] + d2 + 1;
    t[3] = t[2] + d3 + 1;
    for (int k = 1; k <= t[3] + 1; k++) begin
      if (k == chg_k) dly = chg_dly;
      tick(1);
      for (int i = 0; i < 4; i++) e[i] = (k >= t[i]);
      chk({tag, "_dom"}, 32'(dom_rst_n), 32'(e));
      chk({tag, "_rdy"}, 32'(all_rdy), 32'(k >= t[3]));
    end
  endtask

  int fail_hi;

  initial begin
    rst = 1'b1; xrst_n = 1'b1; sw_rst_req = 1'b0; mon_en = 1'b0;
    mon_clk_in = 1'b0; fail_clr = 1'b0;
    dly = {8'd3, 8'd0, 8'd2, 8'd1};

    tick(1);
    chk("rst_dom", 32'(dom_rst_n), 32'h0);
    chk("rst_rdy", 32'(all_rdy), 32'h0);
    chk("rst_fail", 32'(clk_fail), 32'h0);
    chk("rst_fb", 32'(fallback_sel), 32'h0);
    chk("rst_cause", 32'(rst_cause), 32'h0);
    tick(2);
    rst = 1'b0;
    check_seq("por", 1, 2, 0, 3, 0, 32'h0);
    chk("por_cause", 32'(rst_cause), 32'h0);

    // Software reset from RUN
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("sw_dom", 32'(dom_rst_n), 32'h0);
    chk("sw_rdy", 32'(all_rdy), 32'h0);
    chk("sw_cause", 32'(rst_cause), 32'h2);
    check_seq("sw", 1, 2, 0, 3, 0, 32'h0);

    // External reset while domain 2 is counting
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(21);
    chk("x_mid_dom", 32'(dom_rst_n), 32'h3);
    xrst_n = 1'b0;
    tick(3);
    chk("x_lat_dom", 32'(dom_rst_n), 32'h0);
    chk("x_cause", 32'(rst_cause), 32'h1);
    tick(37);
    chk("x_hold_dom", 32'(dom_rst_n), 32'h0);
    chk("x_hold_rdy", 32'(all_rdy), 32'h0);
    xrst_n = 1'b1;
    tick(2);
    check_seq("xrst", 1, 2, 0, 3, 0, 32'h0);

    // Monitor: healthy toggling, then stall
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(3);
      mon_clk_in = ~mon_clk_in;
    end
    chk("mon_ok_fail", 32'(clk_fail), 32'h0);
    chk("mon_ok_fb", 32'(fallback_sel), 32'h0);
    // Last input toggle: synchronized after 2 edges, counter cleared on the 3rd,
    // then 64 cycles to the flag.
    tick(66);
    chk("mon_pre_fail", 32'(clk_fail), 32'h0);
    chk("mon_pre_dom", 32'(dom_rst_n), 32'hF);
    tick(1);
    chk("mon_fail", 32'(clk_fail), 32'h1);
    chk("mon_fb", 32'(fallback_sel), 32'h1);
    chk("mon_dom", 32'(dom_rst_n), 32'h0);
    chk("mon_cause", 32'(rst_cause), 32'h3);
    check_seq("fail", 1, 2, 0, 3, 0, 32'h0);
    chk("fail_sticky", 32'(clk_fail), 32'h1);

    // fail_clr held across a new failure: set must win on that cycle
    fail_clr = 1'b1;
    tick(2);
    chk("clr_fail", 32'(clk_fail), 32'h0);
    chk("clr_fb", 32'(fallback_sel), 32'h0);
    mon_clk_in = ~mon_clk_in;
    fail_hi = 0;
    for (int k = 1; k <= 80; k++) begin
      tick(1);
      if (clk_fail) fail_hi++;
      if (k == 67) chk("setwins_fail", 32'(clk_fail), 32'h1);
    end
    chk("setwins_cnt", 32'(fail_hi), 32'd1);
    fail_clr = 1'b0;
    tick(20);
    chk("setwins_dom", 32'(dom_rst_n), 32'hF);
    chk("setwins_rdy", 32'(all_rdy), 32'h1);
    chk("setwins_cause", 32'(rst_cause), 32'h3);

    // xrst_n and sw_rst_req in the same cycle: external wins
    xrst_n = 1'b0;
    tick(2);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk("prio_cause", 32'(rst_cause), 32'h1);
    chk("prio_dom", 32'(dom_rst_n), 32'h0);
    dly = {8'd5, 8'd0, 8'd2, 8'd1};
    xrst_n = 1'b1;
    tick(2);
    // dly[3] drops 5 -> 0 while domain 1 counts; domain 3 follows domain 2 by 1 cycle.
    check_seq("dlychg", 1, 2, 0, 0, 20, {8'd0, 8'd0, 8'd2, 8'd1});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
